// File: rtl/serializador.sv
`default_nettype none
// ----------------------------------------------------------------------------
// serializador : byte-to-bit serializer, MSB first, with one byte of buffering
//                and a backpressure-aware shift FSM.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module serializador (
  input  logic       clock_100KHz,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enqueue_in,
  input  logic       ready_in,
  output logic       data_out,
  output logic       write_out,
  output logic       status_out,
  output logic       done_out,
  output logic [7:0] byte_count_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic [7:0] r_shreg;
  logic [2:0] r_bit_cnt;

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_hold         <= 8'd0;
      r_hold_valid   <= 1'b0;
      r_shreg        <= 8'd0;
      r_bit_cnt      <= 3'd0;
      data_out       <= 1'b0;
      write_out      <= 1'b0;
      status_out     <= 1'b1;
      done_out       <= 1'b0;
      byte_count_out <= 8'd0;
    end else begin
      done_out <= 1'b0;

      // status_out mirrors !r_hold_valid; capture and load never coincide
      if (enqueue_in && status_out) begin
        r_hold       <= data_in;
        r_hold_valid <= 1'b1;
        status_out   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          write_out <= 1'b0;
          if (r_hold_valid) begin
            r_shreg      <= r_hold;
            r_hold_valid <= 1'b0;
            status_out   <= 1'b1;
            r_bit_cnt    <= 3'd0;
            r_state      <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (ready_in) begin
            data_out  <= r_shreg[7];
            write_out <= 1'b1;
            r_shreg   <= {r_shreg[6:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= S_DONE;
            end
          end else begin
            // stall: keep data_out, shreg and counter so no bit is lost
            write_out <= 1'b0;
          end
        end

        S_DONE: begin
          write_out      <= 1'b0;
          done_out       <= 1'b1;
          byte_count_out <= byte_count_out + 8'd1;
          r_state        <= S_IDLE;
        end

        default: begin
          write_out <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serializador.sv
`default_nettype none
// tb_serializador : directed vector table plus hand-written multi-cycle
// sequences (back-to-back, overflow, reset mid-byte, counter wrap).
`timescale 1ns/1ps
module tb_serializador;

  logic       clock_100KHz = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       enqueue_in;
  logic       ready_in;
  logic       data_out;
  logic       write_out;
  logic       status_out;
  logic       done_out;
  logic [7:0] byte_count_out;

  serializador dut (
    .clock_100KHz  (clock_100KHz),
    .reset         (reset),
    .data_in       (data_in),
    .enqueue_in    (enqueue_in),
    .ready_in      (ready_in),
    .data_out      (data_out),
    .write_out     (write_out),
    .status_out    (status_out),
    .done_out      (done_out),
    .byte_count_out(byte_count_out)
  );

  always #5 clock_100KHz = ~clock_100KHz;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] bits;
  int          nbits;
  int          ndone;
  int          cyc;
  int          done_cyc;
  int          stall_bad;

  typedef struct {
    logic [7:0] data;
    int         stall_after;
    int         stall_len;
    logic [7:0] exp_bits;
    int         exp_done;
    logic [7:0] exp_count;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    bits      = 32'd0;
    nbits     = 0;
    ndone     = 0;
    cyc       = 0;
    done_cyc  = -1;
    stall_bad = 0;
  endtask

  // One clock: inputs set before the rising edge, outputs sampled at the falling edge.
  task automatic step();
    logic rdy;
    rdy = ready_in;
    @(posedge clock_100KHz);
    @(negedge clock_100KHz);
    cyc++;
    if (write_out) begin
      bits = {bits[30:0], data_out};
      nbits++;
    end
    if (!rdy && write_out) stall_bad++;
    if (done_out) begin
      ndone++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int stall_after, input int stall_len);
    int  guard;
    int  left;
    bit  started;
    guard   = 0;
    left    = 0;
    started = 0;
    while (!status_out && guard < 50) begin
      step();
      guard++;
    end
    data_in    = d;
    enqueue_in = 1'b1;
    step();
    enqueue_in = 1'b0;
    clear_obs();
    while (done_cyc < 0 && cyc < 100) begin
      step();
      if (!ready_in) begin
        left--;
        if (left <= 0) ready_in = 1'b1;
      end else if (!started && stall_len > 0 && nbits == stall_after) begin
        started  = 1;
        ready_in = 1'b0;
        left     = stall_len;
      end
    end
    ready_in = 1'b1;
    step();
  endtask

  initial begin
    tbl[0] = '{data: 8'hA5, stall_after: 0, stall_len: 0, exp_bits: 8'hA5, exp_done: 10, exp_count: 8'd1};
    tbl[1] = '{data: 8'hC3, stall_after: 3, stall_len: 5, exp_bits: 8'hC3, exp_done: 15, exp_count: 8'd2};
    tbl[2] = '{data: 8'h81, stall_after: 7, stall_len: 2, exp_bits: 8'h81, exp_done: 12, exp_count: 8'd3};
    tbl[3] = '{data: 8'h00, stall_after: 0, stall_len: 0, exp_bits: 8'h00, exp_done: 10, exp_count: 8'd4};
    tbl[4] = '{data: 8'hFF, stall_after: 1, stall_len: 1, exp_bits: 8'hFF, exp_done: 11, exp_count: 8'd5};

    reset      = 1'b1;
    data_in    = 8'd0;
    enqueue_in = 1'b0;
    ready_in   = 1'b1;
    clear_obs();
    step();
    step();
    check("rst_data_out",   {31'd0, data_out},   32'd0);
    check("rst_write_out",  {31'd0, write_out},  32'd0);
    check("rst_status_out", {31'd0, status_out}, 32'd1);
    check("rst_done_out",   {31'd0, done_out},   32'd0);
    check("rst_byte_count", {24'd0, byte_count_out}, 32'd0);
    reset = 1'b0;
    step();

    // Table of single-byte transfers, some with mid-byte stalls
    for (int i = 0; i < 5; i++) begin
      send_byte(tbl[i].data, tbl[i].stall_after, tbl[i].stall_len);
      check($sformatf("vec%0d_bits", i),       {24'd0, bits[7:0]}, {24'd0, tbl[i].exp_bits});
      check($sformatf("vec%0d_nbits", i),      nbits, 32'd8);
      check($sformatf("vec%0d_done_cyc", i),   done_cyc, tbl[i].exp_done);
      check($sformatf("vec%0d_done_pulses", i), ndone, 32'd1);
      check($sformatf("vec%0d_stall_write", i), stall_bad, 32'd0);
      check($sformatf("vec%0d_count", i),      {24'd0, byte_count_out}, {24'd0, tbl[i].exp_count});
    end

    // Back-to-back: second byte enqueued as soon as the holding buffer frees
    begin
      bit pending;
      int guard;
      clear_obs();
      data_in    = 8'h3C;
      enqueue_in = 1'b1;
      step();
      enqueue_in = 1'b0;
      pending    = 1;
      guard      = 0;
      while (ndone < 2 && guard < 60) begin
        if (pending && status_out) begin
          data_in    = 8'hFF;
          enqueue_in = 1'b1;
          step();
          enqueue_in = 1'b0;
          pending    = 0;
        end else begin
          step();
        end
        guard++;
      end
      for (int k = 0; k < 4; k++) step();
      check("b2b_stream", {16'd0, bits[15:0]}, 32'h0000_3CFF);
      check("b2b_nbits",  nbits, 32'd16);
      check("b2b_done",   ndone, 32'd2);
      check("b2b_count",  {24'd0, byte_count_out}, 32'd7);
    end

    // Overflow: third byte offered while the buffer is full is dropped
    begin
      int guard;
      clear_obs();
      data_in    = 8'h11;
      enqueue_in = 1'b1;
      step();
      enqueue_in = 1'b0;
      step();
      check("ovf_status_after_load", {31'd0, status_out}, 32'd1);
      data_in    = 8'h22;
      enqueue_in = 1'b1;
      step();
      check("ovf_status_full", {31'd0, status_out}, 32'd0);
      data_in    = 8'h33;
      step();
      enqueue_in = 1'b0;
      guard      = 0;
      while (ndone < 2 && guard < 60) begin
        step();
        guard++;
      end
      for (int k = 0; k < 15; k++) step();
      check("ovf_stream", {16'd0, bits[15:0]}, 32'h0000_1122);
      check("ovf_nbits",  nbits, 32'd16);
      check("ovf_done",   ndone, 32'd2);
      check("ovf_count",  {24'd0, byte_count_out}, 32'd9);
    end

    // Reset after the 4th bit of 0x5A with 0x77 held; reset beats a same-edge enqueue
    begin
      int guard;
      clear_obs();
      data_in    = 8'h5A;
      enqueue_in = 1'b1;
      step();
      enqueue_in = 1'b0;
      step();
      data_in    = 8'h77;
      enqueue_in = 1'b1;
      step();
      enqueue_in = 1'b0;
      guard      = 0;
      while (nbits < 4 && guard < 20) begin
        step();
        guard++;
      end
      check("rmb_partial_bits", {28'd0, bits[3:0]}, 32'h5);
      reset      = 1'b1;
      data_in    = 8'h99;
      enqueue_in = 1'b1;
      step();
      reset      = 1'b0;
      enqueue_in = 1'b0;
      check("rmb_write_out",  {31'd0, write_out},  32'd0);
      check("rmb_data_out",   {31'd0, data_out},   32'd0);
      check("rmb_status_out", {31'd0, status_out}, 32'd1);
      check("rmb_done_out",   {31'd0, done_out},   32'd0);
      check("rmb_count",      {24'd0, byte_count_out}, 32'd0);
      clear_obs();
      for (int k = 0; k < 25; k++) step();
      check("rmb_no_bits_after", nbits, 32'd0);
      check("rmb_no_done_after", ndone, 32'd0);
      send_byte(8'h81, 0, 0);
      check("rmb_fresh_bits",  {24'd0, bits[7:0]}, 32'h81);
      check("rmb_fresh_done",  done_cyc, 32'd10);
      check("rmb_fresh_count", {24'd0, byte_count_out}, 32'd1);
    end

    // Counter wrap: 255 more bytes bring the total to 256
    for (int i = 0; i < 255; i++) begin
      send_byte(8'(i), 0, 0);
    end
    check("wrap_256", {24'd0, byte_count_out}, 32'd0);
    send_byte(8'h6B, 0, 0);
    check("wrap_257", {24'd0, byte_count_out}, 32'd1);
    check("wrap_257_bits", {24'd0, bits[7:0]}, 32'h6B);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serializador.md
SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clock_100KHz  input  1  sole clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising edge of clock_100KHz.
REQ-004 data_in  input  8  parallel byte to transmit.
REQ-005 enqueue_in  input  1  byte-valid strobe; accepted only on an edge where status_out=1.
REQ-006 ready_in  input  1  downstream receiver can accept a bit (driven by the receiver's status_out).
REQ-007 data_out  output  1  serial bit, MSB first; registered.
REQ-008 write_out  output  1  bit-valid strobe; data_out is meaningful only while write_out=1.
REQ-009 status_out  output  1  holding buffer free; registered, equals NOT hold_valid.
REQ-010 done_out  output  1  one-cycle pulse after the 8th bit of a byte.
REQ-011 byte_count_out  output  8  bytes fully transmitted, modulo 256.

Function
REQ-012 Storage SHALL be one 8-bit holding register (hold, hold_valid), one 8-bit shift register, and a 3-bit bit counter.
REQ-013 Capture: edge with enqueue_in=1 and status_out=1 -> hold<=data_in, hold_valid<=1; enqueue_in while status_out=0 is ignored (byte dropped, no state change).
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-015 IDLE: if hold_valid=1 -> shift reg<=hold, hold_valid<=0, bit counter<=0, go SHIFT; else stay; write_out<=0.
REQ-016 SHIFT, ready_in=1: data_out<=shreg[7], write_out<=1, shreg<=shreg<<1, bit counter+1; after the bit with counter=7 go DONE.
REQ-017 SHIFT, ready_in=0: write_out<=0, data_out holds last value, shreg and counter unchanged (stall, no bit lost).
REQ-018 DONE: write_out<=0, done_out<=1, byte_count_out+1 (wrap 255->0), go IDLE; done_out<=0 on every other edge.
REQ-019 Latency with ready_in held 1: byte captured at edge N; loaded at N+1; bits 7..0 driven at N+2..N+9; done_out high after N+10; next held byte loads at N+11.
REQ-020 A new byte MAY be captured into hold while SHIFT/DONE is active (status_out=1 after load), giving one byte of buffering.
REQ-021 Capture and load on the same edge cannot occur (capture requires hold_valid=0, load requires hold_valid=1).
REQ-022 enqueue_in and ready_in SHALL be treated as synchronous to clock_100KHz; no synchronizers inside.

Reset
REQ-023 reset=1 SHALL dominate every other input on the same edge.
REQ-024 After reset: state IDLE, hold_valid=0, status_out=1, data_out=0, write_out=0, done_out=0, byte_count_out=0, shreg=0, bit counter=0.
REQ-025 Reset mid-SHIFT SHALL abort the byte: partial byte and held byte discarded, write_out=0 after the reset edge, no done_out pulse.

Verification
REQ-026 Single byte: reset, enqueue 0xA5, ready_in=1 -> write_out high 8 cycles with data_out 1,0,1,0,0,1,0,1; done_out one cycle; byte_count_out=1.
REQ-027 Back-to-back: enqueue 0x3C then 0xFF as soon as status_out=1 -> serial stream 00111100 11111111, two done_out pulses, byte_count_out=2, no lost or duplicated bit.
REQ-028 Stall: 0xC3 with ready_in=0 for 5 cycles after the 3rd bit -> write_out=0 during stall, stream still 11000011, done_out 5 cycles later than unstalled.
REQ-029 Overflow: enqueue 0x11 (loading), 0x22 (held), 0x33 while status_out=0 -> only 0x11, 0x22 transmitted, byte_count_out=2.
REQ-030 Reset mid-byte: reset after 4th bit of 0x5A -> outputs at reset values next cycle, byte_count_out=0; fresh 0x81 then sends 10000001 correctly.
REQ-031 Wrap: 256 bytes transmitted -> byte_count_out reads 0; 257th -> 1.
